// File: rtl/vmem_sched_pkg.sv
// vmem_sched_pkg: shared state encoding and requester IDs for the vector memory scheduler.
package vmem_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOST  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_ENG  = 1'b1;
endpackage

// File: rtl/vmem_rr_arb.sv
// vmem_rr_arb: 2-way round-robin pick between host and engine; the last-winner register lives in the caller.
module vmem_rr_arb
  import vmem_sched_pkg::*;
(
  input  logic       req_host,
  input  logic       req_eng,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = '0;
    gnt[REQ_HOST] = req_host && (!req_eng || last == REQ_ENG);
    gnt[REQ_ENG] = req_eng && (!req_host || last == REQ_HOST);
  end
endmodule

// File: rtl/vmem_sched.sv
// vmem_sched: shares one vector-memory port between host scalar accesses and engine bursts.
// Optional VMEM_SCHED_ABORT_EN adds eng_abort_i / eng_aborted_o to cut a burst short.
module vmem_sched
  import vmem_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int VMAX       = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_req_i,
  input  logic                       host_we_i,
  input  logic [ADDR_WIDTH-1:0]      host_addr_i,
  input  logic [DATA_WIDTH-1:0]      host_wdata_i,
  output logic                       host_gnt_o,
  output logic                       host_rvalid_o,
  output logic [DATA_WIDTH-1:0]      host_rdata_o,
  input  logic                       eng_start_i,
  input  logic                       eng_we_i,
  input  logic [ADDR_WIDTH-1:0]      eng_base_i,
  input  logic [LEN_WIDTH-1:0]       eng_len_i,
  input  logic                       eng_ready_i,
  input  logic [DATA_WIDTH*VMAX-1:0] eng_wdata_i,
  output logic                       eng_busy_o,
  output logic                       eng_rvalid_o,
  output logic [DATA_WIDTH*VMAX-1:0] eng_rdata_o,
  output logic                       eng_done_o,
  output logic [ADDR_WIDTH-1:0]      mem_waddr_o,
  output logic [ADDR_WIDTH-1:0]      mem_raddr_o,
  output logic                       mem_is_working_o,
  output logic                       mem_wen_o,
  output logic                       mem_ren_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_scalar_o,
  output logic [DATA_WIDTH*VMAX-1:0] mem_wdata_vector_o,
`ifdef VMEM_SCHED_ABORT_EN
  input  logic                       eng_abort_i,
  output logic                       eng_aborted_o,
`endif
  input  logic [DATA_WIDTH*VMAX-1:0] mem_rdata_i
);
  localparam int VW = DATA_WIDTH * VMAX;
  state_t state, state_d;
  logic [1:0] gnt;
  logic last_q, accept, abort, last_beat;
  logic h_we_q, e_we_q;
  logic [ADDR_WIDTH-1:0] h_addr_q, e_base_q, beat_addr;
  logic [DATA_WIDTH-1:0] h_wdata_q, rdata_q;
  logic [LEN_WIDTH-1:0] e_len_q, beat_q;
  logic rvalid_q, h_wr, h_rd, b_wr, b_rd;

  vmem_rr_arb u_arb (
    .req_host(host_req_i),
    .req_eng (eng_start_i),
    .last    (last_q),
    .gnt     (gnt)
  );

  assign accept = state == IDLE && |gnt;
  assign beat_addr = e_base_q + ADDR_WIDTH'(32'(beat_q) * VMAX);
  assign last_beat = beat_q == e_len_q - LEN_WIDTH'(1);
  assign h_wr = state == HOST && h_we_q;
  assign h_rd = state == HOST && !h_we_q;
  assign b_wr = state == BURST && e_we_q;
  assign b_rd = state == BURST && !e_we_q;

`ifdef VMEM_SCHED_ABORT_EN
  logic aborted_q;
  assign abort = state == BURST && eng_abort_i;
  assign eng_aborted_o = aborted_q;
  // abort always lands in DONE next cycle, so a one-cycle flag lines up with eng_done_o
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) aborted_q <= 1'b0;
    else aborted_q <= abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = gnt[REQ_HOST] ? HOST : gnt[REQ_ENG] ? (eng_len_i == '0 ? DONE : BURST) : IDLE;
      HOST:    state_d = IDLE;
      BURST:   state_d = (abort || (eng_ready_i && last_beat)) ? DONE : BURST;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_q    <= REQ_ENG;
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      e_we_q    <= 1'b0;
      e_base_q  <= '0;
      e_len_q   <= '0;
      beat_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) last_q <= gnt[REQ_ENG] ? REQ_ENG : REQ_HOST;
      if (state == IDLE && gnt[REQ_HOST]) begin
        h_we_q    <= host_we_i;
        h_addr_q  <= host_addr_i;
        h_wdata_q <= host_wdata_i;
      end
      if (state == IDLE && gnt[REQ_ENG]) begin
        e_we_q   <= eng_we_i;
        e_base_q <= eng_base_i;
        e_len_q  <= eng_len_i;
        beat_q   <= '0;
      end else if (state == BURST && eng_ready_i) beat_q <= beat_q + LEN_WIDTH'(1);
      rvalid_q <= h_rd;
      rdata_q  <= h_rd ? mem_rdata_i[VW-1 -: DATA_WIDTH] : '0;
    end

  always_comb begin
    host_gnt_o         = state == HOST;
    host_rvalid_o      = rvalid_q;
    host_rdata_o       = rdata_q;
    eng_busy_o         = state == BURST || state == DONE;
    eng_done_o         = state == DONE;
    eng_rvalid_o       = b_rd;
    eng_rdata_o        = b_rd ? mem_rdata_i : '0;
    mem_is_working_o   = state == BURST;
    mem_wen_o          = h_wr || (b_wr && eng_ready_i && !abort);
    mem_ren_o          = h_rd || b_rd;
    mem_waddr_o        = h_wr ? h_addr_q : b_wr ? beat_addr : '0;
    mem_raddr_o        = h_rd ? h_addr_q : b_rd ? beat_addr : '0;
    mem_wdata_scalar_o = h_wr ? h_wdata_q : '0;
    mem_wdata_vector_o = b_wr ? eng_wdata_i : '0;
  end
endmodule

// File: tb/tb_vmem_sched.sv
// tb_vmem_sched: table-driven host/burst vectors with a write/read scoreboard against a behavioral vector memory.
module tb_vmem_sched;
  localparam int DW = 16, AW = 10, VM = 8, LW = 8, VW = DW * VM;
  typedef logic [511:0] w_t;
  typedef struct {logic vec; logic [AW-1:0] addr; logic [VW-1:0] data; int cyc;} wr_t;
  typedef struct {logic [AW-1:0] addr; logic [VW-1:0] data; int cyc;} rd_t;
  typedef struct {logic [DW-1:0] data; int cyc;} hr_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp_rdata;} host_t;
  typedef struct {logic we; logic [AW-1:0] base; logic [LW-1:0] len; logic [7:0] stall; int exp_done;} burst_t;

  logic clk = 0, rst_n = 1;
  logic host_req_i = 0, host_we_i = 0, host_gnt_o, host_rvalid_o;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_wdata_i = '0, host_rdata_o, mem_wdata_scalar_o;
  logic eng_start_i = 0, eng_we_i = 0, eng_ready_i = 0, eng_busy_o, eng_rvalid_o, eng_done_o;
  logic [AW-1:0] eng_base_i = '0, mem_waddr_o, mem_raddr_o;
  logic [LW-1:0] eng_len_i = '0;
  logic [VW-1:0] eng_wdata_i = '0, eng_rdata_o, mem_wdata_vector_o, mem_rdata_i;
  logic mem_is_working_o, mem_wen_o, mem_ren_o;
`ifdef VMEM_SCHED_ABORT_EN
  logic eng_abort_i = 0, eng_aborted_o;
`endif

  int errors = 0, checks = 0, cyc_cnt = 0;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_mem [1024];
  wr_t wq[$];
  rd_t rq[$];
  hr_t hq[$];
  wr_t w_m;
  rd_t r_m;
  hr_t h_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  vmem_sched dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .eng_start_i(eng_start_i), .eng_we_i(eng_we_i), .eng_base_i(eng_base_i), .eng_len_i(eng_len_i),
    .eng_ready_i(eng_ready_i), .eng_wdata_i(eng_wdata_i), .eng_busy_o(eng_busy_o), .eng_rvalid_o(eng_rvalid_o),
    .eng_rdata_o(eng_rdata_o), .eng_done_o(eng_done_o),
    .mem_waddr_o(mem_waddr_o), .mem_raddr_o(mem_raddr_o), .mem_is_working_o(mem_is_working_o),
    .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o), .mem_wdata_scalar_o(mem_wdata_scalar_o),
    .mem_wdata_vector_o(mem_wdata_vector_o),
`ifdef VMEM_SCHED_ABORT_EN
    .eng_abort_i(eng_abort_i), .eng_aborted_o(eng_aborted_o),
`endif
    .mem_rdata_i(mem_rdata_i)
  );

  // behavioral memory: vector mode spans VMAX elements with element 0 in the MSB slice
  always_comb begin
    mem_rdata_i = '0;
    for (int e = 0; e < VM; e++)
      mem_rdata_i[VW-1-e*DW -: DW] = mem_is_working_o ? mem[mem_raddr_o + AW'(e)] : (e == 0 ? mem[mem_raddr_o] : '0);
  end

  always @(posedge clk)
    if (mem_wen_o)
      for (int e = 0; e < VM; e++)
        if (mem_is_working_o) mem[mem_waddr_o + AW'(e)] = mem_wdata_vector_o[VW-1-e*DW -: DW];
        else if (e == 0) mem[mem_waddr_o] = mem_wdata_scalar_o;

  task automatic chk(input string n, input w_t a, input w_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [VW-1:0] wvec(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int e = 0; e < VM; e++) v[VW-1-e*DW -: DW] = 16'h5A00 ^ DW'(a) ^ DW'(e * 273);
    return v;
  endfunction

  function automatic logic [VW-1:0] evec(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int e = 0; e < VM; e++) v[VW-1-e*DW -: DW] = exp_mem[a + AW'(e)];
    return v;
  endfunction

  function automatic w_t all_out();
    return w_t'({host_gnt_o, host_rvalid_o, host_rdata_o, eng_busy_o, eng_rvalid_o, eng_rdata_o, eng_done_o,
                 mem_waddr_o, mem_raddr_o, mem_is_working_o, mem_wen_o, mem_ren_o, mem_wdata_scalar_o, mem_wdata_vector_o});
  endfunction

  task automatic push_vwrite(input logic [AW-1:0] a, input int t);
    logic [VW-1:0] v;
    v = wvec(a);
    wq.push_back('{1'b1, a, v, t});
    for (int e = 0; e < VM; e++) exp_mem[a + AW'(e)] = v[VW-1-e*DW -: DW];
  endtask

  // scoreboard: every memory write, host read return and accepted engine read beat is matched in order
  always @(negedge clk)
    if (rst_n) begin
      if (mem_wen_o) begin
        if (wq.size() == 0) bad("unexpected_write");
        else begin
          w_m = wq.pop_front();
          chk("wr_mode", w_t'(mem_is_working_o), w_t'(w_m.vec));
          chk("wr_addr", w_t'(mem_waddr_o), w_t'(w_m.addr));
          chk("wr_data", w_t'(w_m.vec ? mem_wdata_vector_o : VW'(mem_wdata_scalar_o)), w_t'(w_m.data));
          chk("wr_cycle", w_t'(cyc_cnt), w_t'(w_m.cyc));
        end
      end
      if (host_rvalid_o) begin
        if (hq.size() == 0) bad("unexpected_host_rvalid");
        else begin
          h_m = hq.pop_front();
          chk("host_rdata", w_t'(host_rdata_o), w_t'(h_m.data));
          chk("host_rvalid_cycle", w_t'(cyc_cnt), w_t'(h_m.cyc));
        end
      end
      if (eng_rvalid_o && eng_ready_i) begin
        if (rq.size() == 0) bad("unexpected_eng_beat");
        else begin
          r_m = rq.pop_front();
          chk("eng_raddr", w_t'(mem_raddr_o), w_t'(r_m.addr));
          chk("eng_rdata", w_t'(eng_rdata_o), w_t'(r_m.data));
          chk("eng_beat_cycle", w_t'(cyc_cnt), w_t'(r_m.cyc));
        end
      end
    end

  task automatic run_host(input host_t h);
    int t0;
    t0 = cyc_cnt;
    host_req_i = 1; host_we_i = h.we; host_addr_i = h.addr; host_wdata_i = h.wdata;
    if (h.we) begin
      wq.push_back('{1'b0, h.addr, VW'(h.wdata), t0 + 1});
      exp_mem[h.addr] = h.wdata;
    end else hq.push_back('{h.exp_rdata, t0 + 2});
    sample(); chk("host_gnt_c0", w_t'(host_gnt_o), '0);
    step(); sample();
    chk("host_gnt", w_t'(host_gnt_o), w_t'(1));
    chk("host_scalar_mode", w_t'(mem_is_working_o), '0);
    step(); host_req_i = 0;
  endtask

  task automatic run_burst(input burst_t b);
    int beat, cyc;
    bit done;
    logic [AW-1:0] a;
    beat = 0; cyc = 1; done = 0;
    eng_start_i = 1; eng_we_i = b.we; eng_base_i = b.base; eng_len_i = b.len; eng_ready_i = 1;
    sample(); chk("burst_busy_c0", w_t'(eng_busy_o), '0);
    step();
    while (!done && cyc < 40) begin
      a = b.base + AW'(beat * VM);
      eng_ready_i = !(cyc <= 8 && b.stall[cyc-1]);
      eng_wdata_i = wvec(a);
      if (beat < int'(b.len) && eng_ready_i) begin
        if (b.we) push_vwrite(a, cyc_cnt);
        else rq.push_back('{a, evec(a), cyc_cnt});
      end
      sample();
      if (cyc == 1) begin
        chk("burst_busy_c1", w_t'(eng_busy_o), w_t'(1));
        eng_start_i = 0;
      end
      if (eng_done_o) begin
        done = 1;
        chk("done_cycle", w_t'(cyc), w_t'(b.exp_done));
        chk("done_no_enable", w_t'({mem_wen_o, mem_ren_o}), '0);
      end else if (beat < int'(b.len)) begin
        chk("burst_vec_mode", w_t'(mem_is_working_o), w_t'(1));
        chk("burst_addr", w_t'(b.we ? mem_waddr_o : mem_raddr_o), w_t'(a));
        if (eng_ready_i) beat++;
      end
      step(); cyc++;
    end
    if (!done) bad("burst_done_timeout");
    eng_start_i = 0;
  endtask

  host_t ht[7];
  burst_t bt[6];

  initial begin
    int t0;
    ht[0] = '{1'b1, 10'd5,    16'hBEEF, 16'h0000};
    ht[1] = '{1'b0, 10'd5,    16'h0000, 16'hBEEF};
    ht[2] = '{1'b1, 10'd1023, 16'h1234, 16'h0000};
    ht[3] = '{1'b0, 10'd1023, 16'h0000, 16'h1234};
    ht[4] = '{1'b0, 10'd200,  16'h0000, 16'hC0C8};
    ht[5] = '{1'b1, 10'd6,    16'hA5A5, 16'h0000};
    ht[6] = '{1'b0, 10'd6,    16'h0000, 16'hA5A5};
    bt[0] = '{1'b1, 10'd0,    8'd2, 8'b0000_0000, 3};
    bt[1] = '{1'b0, 10'd1016, 8'd2, 8'b0000_0001, 4};
    bt[2] = '{1'b1, 10'd100,  8'd3, 8'b0000_0010, 5};
    bt[3] = '{1'b0, 10'd0,    8'd2, 8'b0000_0000, 3};
    bt[4] = '{1'b1, 10'd7,    8'd0, 8'b0000_0000, 1};
    bt[5] = '{1'b0, 10'd3,    8'd0, 8'b0000_0000, 1};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'hC000 ^ DW'(i);
      exp_mem[i] = 16'hC000 ^ DW'(i);
    end
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    sample(); chk("reset_outputs", all_out(), '0);
    step(); rst_n = 1;
    sample(); chk("post_reset_idle", all_out(), '0);
    step();

    // simultaneous requests after reset: host first, engine next, host again after the burst
    t0 = cyc_cnt;
    host_req_i = 1; host_we_i = 1; host_addr_i = 10'd300; host_wdata_i = 16'h3003;
    eng_start_i = 1; eng_we_i = 1; eng_base_i = 10'd400; eng_len_i = 8'd1; eng_ready_i = 1; eng_wdata_i = wvec(10'd400);
    wq.push_back('{1'b0, 10'd300, VW'(16'h3003), t0 + 1}); exp_mem[300] = 16'h3003;
    step(); sample();
    chk("arb_host_first", w_t'(host_gnt_o), w_t'(1));
    chk("arb_eng_waits", w_t'(eng_busy_o), '0);
    step(); host_req_i = 0;
    sample(); chk("arb_eng_idle_cycle", w_t'(eng_busy_o), '0);
    step(); push_vwrite(10'd400, t0 + 3);
    host_req_i = 1; host_we_i = 0; hq.push_back('{16'h3003, t0 + 7});
    sample();
    chk("arb_burst_busy", w_t'(eng_busy_o), w_t'(1));
    chk("arb_host_held", w_t'(host_gnt_o), '0);
    eng_start_i = 0;
    step(); eng_start_i = 1; eng_base_i = 10'd500; eng_wdata_i = wvec(10'd500);
    sample(); chk("arb_done", w_t'(eng_done_o), w_t'(1));
    step(); sample(); chk("arb_idle_no_gnt", w_t'(host_gnt_o), '0);
    step(); sample();
    chk("arb_host_after_burst", w_t'(host_gnt_o), w_t'(1));
    chk("arb_eng_deferred", w_t'(eng_busy_o), '0);
    step(); host_req_i = 0;
    sample(); chk("arb_eng_accept_cycle", w_t'(eng_busy_o), '0);
    step(); push_vwrite(10'd500, t0 + 8);
    sample(); chk("arb_second_burst", w_t'(eng_busy_o), w_t'(1)); eng_start_i = 0;
    step(); sample(); chk("arb_second_done", w_t'(eng_done_o), w_t'(1));
    step();

    for (int i = 0; i < 7; i++) run_host(ht[i]);
    for (int i = 0; i < 6; i++) run_burst(bt[i]);

    // reset in the middle of a len-4 write burst
    t0 = cyc_cnt;
    eng_start_i = 1; eng_we_i = 1; eng_base_i = 10'd600; eng_len_i = 8'd4; eng_ready_i = 1; eng_wdata_i = wvec(10'd600);
    step(); push_vwrite(10'd600, t0 + 1);
    sample(); eng_start_i = 0;
    step(); eng_wdata_i = wvec(10'd608); push_vwrite(10'd608, t0 + 2);
    sample();
    step(); rst_n = 0;
    #1 chk("reset_mid_burst_outputs", all_out(), '0);
    sample(); chk("no_done_in_reset", w_t'(eng_done_o), '0);
    step(); step(); rst_n = 1;
    sample(); chk("no_done_after_reset", w_t'({eng_done_o, eng_busy_o}), '0);
    step();
    run_host('{1'b1, 10'd650, 16'h0650, 16'h0000});
    run_host('{1'b0, 10'd650, 16'h0000, 16'h0650});

`ifdef VMEM_SCHED_ABORT_EN
    t0 = cyc_cnt;
    eng_start_i = 1; eng_we_i = 1; eng_base_i = 10'd700; eng_len_i = 8'd4; eng_ready_i = 1; eng_wdata_i = wvec(10'd700);
    step(); push_vwrite(10'd700, t0 + 1);
    sample(); eng_start_i = 0;
    step(); eng_abort_i = 1; eng_wdata_i = wvec(10'd708);
    sample(); chk("abort_no_write", w_t'(mem_wen_o), '0);
    step(); eng_abort_i = 0;
    sample();
    chk("abort_done", w_t'(eng_done_o), w_t'(1));
    chk("abort_flag", w_t'(eng_aborted_o), w_t'(1));
    step(); sample(); chk("abort_idle", w_t'({eng_busy_o, eng_aborted_o}), '0);
    step();
`endif

    step(); sample();
    chk("wq_drained", w_t'(wq.size()), '0);
    chk("hq_drained", w_t'(hq.size()), '0);
    chk("rq_drained", w_t'(rq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
